// File: rtl/fc2_classifier.sv
// fc2_classifier: second FC layer (128 -> 10) with a serial MAC and argmax.
// Weights/biases come from the shared parameter ROM; scores are saturated Q5.10.
module fc2_classifier #(
  parameter int          BIT     = 16,
  parameter int          FRAC    = 10,
  parameter int          N_IN    = 128,
  parameter int          N_OUT   = 10,
  parameter int          ROM_LAT = 2,
  parameter logic [10:0] W_BASE  = 11'h410,
  parameter logic [10:0] B_BASE  = 11'h41A
) (
  input  logic                   clk,
  input  logic                   iRst_n,
  input  logic                   ena,
  input  logic                   iValid,
  input  logic [N_IN*BIT-1:0]    iData,
  input  logic [128*BIT-1:0]     data_from_rom,
  output logic [10:0]            addr_to_rom,
  output logic [N_OUT*BIT-1:0]   oScores,
  output logic [3:0]             oDigit,
  output logic                   oBusy,
  output logic                   oDone
);

  localparam int ACC_W = 2*BIT + 8;
  localparam int WW    = $clog2(ROM_LAT + 1);
  localparam int IW    = $clog2(N_IN);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_BIAS, S_WAIT_B, S_ROW_ADDR,
    S_WAIT_W, S_MAC, S_BIAS, S_STORE, S_DONE
  } state_t;

  state_t                   r_state, w_next;
  logic [N_IN*BIT-1:0]      r_act;
  logic [N_IN*BIT-1:0]      r_w;
  logic [N_OUT*BIT-1:0]     r_bias;
  logic [N_OUT*BIT-1:0]     r_scores;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [BIT-1:0]    r_best;
  logic [WW-1:0]            r_wait;
  logic [IW-1:0]            r_i;
  logic [3:0]               r_j;
  logic [3:0]               r_digit;
  logic [10:0]              r_addr;
  logic                     r_done;

  logic                     w_wlast;
  logic                     w_ilast;
  logic                     w_jlast;
  logic [3:0]               w_jn;
  logic signed [2*BIT-1:0]  w_prod;
  logic signed [BIT-1:0]    w_bsel;
  logic signed [ACC_W-1:0]  w_padd;
  logic signed [ACC_W-1:0]  w_badd;
  logic signed [ACC_W-1:0]  w_sh;
  logic                     w_povf;
  logic                     w_novf;
  logic signed [BIT-1:0]    w_sat;

  assign w_wlast = (r_wait == WW'(ROM_LAT - 1));
  assign w_ilast = (r_i == IW'(N_IN - 1));
  assign w_jlast = (r_j == 4'(N_OUT - 1));
  assign w_jn    = r_j + 4'd1;

  // Activations rotate and weights shift so element 0 is always the MAC operand.
  assign w_prod = $signed(r_act[BIT-1:0]) * $signed(r_w[BIT-1:0]);
  assign w_padd = {{(ACC_W-2*BIT){w_prod[2*BIT-1]}}, w_prod};
  assign w_bsel = r_bias[r_j*BIT +: BIT];
  assign w_badd = {{(ACC_W-BIT-FRAC){w_bsel[BIT-1]}}, w_bsel, {FRAC{1'b0}}};

  assign w_sh   = r_acc >>> FRAC;
  assign w_povf = !w_sh[ACC_W-1] && (|w_sh[ACC_W-2:BIT-1]);
  assign w_novf = w_sh[ACC_W-1] && !(&w_sh[ACC_W-2:BIT-1]);
  assign w_sat  = w_povf ? {1'b0, {(BIT-1){1'b1}}} :
                  w_novf ? {1'b1, {(BIT-1){1'b0}}} :
                  w_sh[BIT-1:0];

  always_ff @(posedge clk) begin
    if (!iRst_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (ena) begin
      unique case (r_state)
        S_IDLE:     if (iValid) w_next = S_LD_BIAS;
        S_LD_BIAS:  w_next = S_WAIT_B;
        S_WAIT_B:   if (w_wlast) w_next = S_ROW_ADDR;
        S_ROW_ADDR: w_next = S_WAIT_W;
        S_WAIT_W:   if (w_wlast) w_next = S_MAC;
        S_MAC:      if (w_ilast) w_next = S_BIAS;
        S_BIAS:     w_next = S_STORE;
        S_STORE:    w_next = w_jlast ? S_DONE : S_ROW_ADDR;
        S_DONE:     if (!iValid) w_next = S_IDLE;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      r_act    <= '0;
      r_w      <= '0;
      r_bias   <= '0;
      r_scores <= '0;
      r_acc    <= '0;
      r_best   <= '0;
      r_wait   <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_digit  <= '0;
      r_addr   <= '0;
      r_done   <= 1'b0;
    end else if (ena) begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (iValid) begin
            r_act  <= iData;
            r_j    <= '0;
            r_best <= '0;
            r_addr <= B_BASE;
          end
        end
        S_LD_BIAS: r_wait <= '0;
        S_WAIT_B: begin
          r_wait <= r_wait + WW'(1);
          if (w_wlast) begin
            r_bias <= data_from_rom[N_OUT*BIT-1:0];
            r_addr <= W_BASE;
          end
        end
        S_ROW_ADDR: begin
          r_acc  <= '0;
          r_i    <= '0;
          r_wait <= '0;
        end
        S_WAIT_W: begin
          r_wait <= r_wait + WW'(1);
          if (w_wlast) r_w <= data_from_rom[N_IN*BIT-1:0];
        end
        S_MAC: begin
          r_acc <= r_acc + w_padd;
          r_i   <= r_i + IW'(1);
          r_act <= {r_act[BIT-1:0], r_act[N_IN*BIT-1:BIT]};
          r_w   <= {{BIT{1'b0}}, r_w[N_IN*BIT-1:BIT]};
        end
        S_BIAS: r_acc <= r_acc + w_badd;
        S_STORE: begin
          r_scores[r_j*BIT +: BIT] <= w_sat;
          if (r_j == 4'd0 || w_sat > r_best) begin
            r_best  <= w_sat;
            r_digit <= r_j;
          end
          r_j <= w_jn;
          if (!w_jlast) r_addr <= W_BASE + {7'd0, w_jn};
        end
        S_DONE:  r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign addr_to_rom = r_addr;
  assign oScores     = r_scores;
  assign oDigit      = r_digit;
  assign oDone       = r_done;
  assign oBusy       = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule

// File: tb/tb_fc2_classifier.sv
// Scoreboard bench for fc2_classifier: directed runs against a 2-cycle ROM model.
// Expected scores/digit/latency are queued at start; a monitor checks on oDone.
module tb_fc2_classifier;

  localparam int BIT   = 16;
  localparam int N_IN  = 128;
  localparam int N_OUT = 10;
  localparam logic [10:0] W_BASE = 11'h410;
  localparam logic [10:0] B_BASE = 11'h41A;

  logic                  clk = 1'b0;
  logic                  iRst_n = 1'b0;
  logic                  ena = 1'b1;
  logic                  iValid = 1'b0;
  logic [N_IN*BIT-1:0]   iData = '0;
  logic [128*BIT-1:0]    data_from_rom = '0;
  logic [128*BIT-1:0]    rom_d1 = '0;
  logic [10:0]           addr_to_rom;
  logic [N_OUT*BIT-1:0]  oScores;
  logic [3:0]            oDigit;
  logic                  oBusy;
  logic                  oDone;

  fc2_classifier dut (
    .clk(clk), .iRst_n(iRst_n), .ena(ena), .iValid(iValid),
    .iData(iData), .data_from_rom(data_from_rom),
    .addr_to_rom(addr_to_rom), .oScores(oScores), .oDigit(oDigit),
    .oBusy(oBusy), .oDone(oDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_OUT*BIT-1:0] s;
    logic [3:0]           d;
    int                   t0;
    int                   lat;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  logic [128*BIT-1:0]   wword [N_OUT];
  logic [128*BIT-1:0]   bword;
  logic [N_OUT*BIT-1:0] exp_s;
  logic [3:0]           exp_d;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [128*BIT-1:0] rom_word(input logic [10:0] a);
    if (a == B_BASE) return bword;
    if (a >= W_BASE && a < W_BASE + 11'(N_OUT)) return wword[a - W_BASE];
    return '0;
  endfunction

  always @(posedge clk) begin
    rom_d1        <= rom_word(addr_to_rom);
    data_from_rom <= rom_d1;
  end

  task automatic chk(input string nm, input logic [N_OUT*BIT-1:0] got,
                     input logic [N_OUT*BIT-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (oDone && !prev_done) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end else begin
        e = sbq.pop_front();
        chk("scores", oScores, e.s);
        chk("digit", {156'd0, oDigit}, {156'd0, e.d});
        chk("done_latency", (cyc - e.t0 - 1), e.lat);
        chk("busy_at_done", {159'd0, oBusy}, '0);
      end
    end
    prev_done = oDone;
  end

  task automatic clear_data();
    iData = '0;
    bword = '0;
    for (int j = 0; j < N_OUT; j++) wword[j] = '0;
  endtask

  task automatic set_bias_only();
    clear_data();
    for (int j = 0; j < N_OUT; j++) begin
      bword[j*BIT +: BIT] = (j == 7) ? 16'h0C00 : 16'(j * 16'h0100);
      exp_s[j*BIT +: BIT] = (j == 7) ? 16'h0C00 : 16'(j * 16'h0100);
    end
    exp_d = 4'd7;
  endtask

  task automatic set_single_weight();
    clear_data();
    iData[BIT-1:0] = 16'h0400;
    for (int j = 0; j < N_OUT; j++) begin
      wword[j][BIT-1:0] = 16'(j * 16'h0200);
      exp_s[j*BIT +: BIT] = 16'(j * 16'h0200);
    end
    exp_d = 4'd9;
  endtask

  task automatic set_sat(input logic [BIT-1:0] wv, input logic [BIT-1:0] sv);
    clear_data();
    for (int i = 0; i < N_IN; i++) iData[i*BIT +: BIT] = 16'h7FFF;
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) wword[j][i*BIT +: BIT] = wv;
      exp_s[j*BIT +: BIT] = sv;
    end
    exp_d = 4'd0;
  endtask

  task automatic set_negative();
    clear_data();
    for (int j = 0; j < N_OUT; j++) begin
      bword[j*BIT +: BIT] = (j == 3) ? 16'hFF00 : 16'(16'hE000 - j * 16'h0100);
      exp_s[j*BIT +: BIT] = (j == 3) ? 16'hFF00 : 16'(16'hE000 - j * 16'h0100);
    end
    exp_d = 4'd3;
  endtask

  task automatic run(input int lat, input int ena_at, input int rst_at);
    exp_t e;
    bit   hit;
    @(negedge clk);
    iValid = 1'b1;
    e.s  = exp_s;
    e.d  = exp_d;
    e.t0 = cyc;
    e.lat = lat;
    if (rst_at < 0) sbq.push_back(e);
    hit = 1'b0;
    for (int k = 1; k <= 3000 && !hit; k++) begin
      @(negedge clk);
      if (k == 10) chk("busy_in_run", {159'd0, oBusy}, 1);
      if (k == ena_at) ena = 1'b0;
      if (k == ena_at + 50) ena = 1'b1;
      if (k == rst_at) begin
        iRst_n = 1'b0;
        iValid = 1'b0;
        repeat (2) @(negedge clk);
        iRst_n = 1'b1;
        chk("abort_scores", oScores, '0);
        chk("abort_busy", {159'd0, oBusy}, '0);
        return;
      end
      hit = oDone;
    end
    if (!hit) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got 0 expected 1");
    end
    iValid = 1'b0;
    @(negedge clk);
    chk("done_hold", {159'd0, oDone}, 1);
    @(negedge clk);
    chk("done_fall", {159'd0, oDone}, '0);
  endtask

  initial begin
    clear_data();
    exp_s = '0;
    exp_d = '0;
    iRst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      iValid = 1'($urandom);
      ena    = 1'($urandom);
      for (int i = 0; i < N_IN; i++) iData[i*BIT +: BIT] = 16'($urandom);
    end
    @(negedge clk);
    iRst_n = 1'b1;
    iValid = 1'b0;
    ena    = 1'b1;
    chk("rst_scores", oScores, '0);
    chk("rst_digit", {156'd0, oDigit}, '0);
    chk("rst_busy", {159'd0, oBusy}, '0);
    chk("rst_done", {159'd0, oDone}, '0);
    chk("rst_addr", {149'd0, addr_to_rom}, '0);
    repeat (6) @(negedge clk);
    chk("idle_addr", {149'd0, addr_to_rom}, '0);
    chk("idle_busy", {159'd0, oBusy}, '0);

    set_bias_only();     run(1334, -1, -1);
    set_single_weight(); run(1334, -1, -1);
    set_sat(16'h7FFF, 16'h7FFF); run(1334, -1, -1);
    set_sat(16'h8000, 16'h8000); run(1334, -1, -1);
    set_negative();      run(1334, -1, -1);
    set_bias_only();     run(1334, -1, 500);
    repeat (3) @(negedge clk);
    set_bias_only();     run(1334, -1, -1);
    set_single_weight(); run(1384, 300, -1);

    repeat (5) @(negedge clk);
    chk("queue_empty", sbq.size(), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fc2_classifier.md
# fc2_classifier

Second fully-connected layer and argmax stage of the handwritten-digit network. It consumes the 128 ReLU activations produced by the first FC layer and computes 10 class scores using a serial multiply-accumulate engine. Weights and biases come from the shared parameter ROM. The block emits the per-class scores and the index of the winning class (the recognised digit) to the display/output logic.

## Interface
- BIT, 16, fixed-point word width; signed Q5.10 (sign, 5 integer, 10 fraction)
- FRAC, 10, fraction bits
- N_IN, 128, input activations
- N_OUT, 10, output classes
- ROM_LAT, 2, cycles from addr_to_rom change to valid data_from_rom
- W_BASE, 11'h410, ROM address of weight word for class 0; class j at W_BASE+j
- B_BASE, 11'h41A, ROM address of bias word
- clk  in  1  clock
- iRst_n  in  1  reset, synchronous, active-low
- ena  in  1  enable; 0 freezes all state and outputs (no progress)
- iValid  in  1  upstream activations valid (upstream done)
- iData  in  N_IN*BIT  activation i at [i*BIT +: BIT]
- data_from_rom  in  128*BIT  ROM word
- addr_to_rom  out  11  ROM address
- oScores  out  N_OUT*BIT  score j at [j*BIT +: BIT], signed Q5.10
- oDigit  out  4  argmax index
- oBusy  out  1  high from leaving IDLE until DONE
- oDone  out  1  result valid

## Operation
- Reset (iRst_n=0 at clk edge, overrides ena): state IDLE, addr_to_rom=0, oScores=0, oDigit=0, oBusy=0, oDone=0, counters/accumulator cleared. Reset mid-operation aborts; no partial result is kept.
- States: IDLE -> LD_BIAS -> WAIT_B -> ROW_ADDR -> WAIT_W -> MAC -> BIAS -> STORE -> (ROW_ADDR | DONE).
- IDLE: when iValid=1, latch iData into the activation register, clear row counter j and best score, go to LD_BIAS.
- LD_BIAS: addr_to_rom=B_BASE. WAIT_B: ROM_LAT cycles; on the last one, capture the bias slots [j*BIT +: BIT] for j<N_OUT.
- ROW_ADDR: addr_to_rom=W_BASE+j, acc=0, i=0. WAIT_W: ROM_LAT cycles; on the last one, capture the weight word. Weight w[j][i] is at [i*BIT +: BIT].
- MAC: one product per cycle, i=0..N_IN-1. acc += sext(a[i]*w[j][i]). Each product is a 2*BIT signed Q10.20 value. acc is 2*BIT+8 bits signed and never overflows.
- BIAS: acc += sext(b[j]) << FRAC.
- STORE: r = acc >>> FRAC (arithmetic, truncation toward -inf). Saturate r to [0x8000, 0x7FFF] and write it to score slot j. No ReLU.
  - If j==0 or r > best (signed, strict), set best=r and oDigit=j. Ties keep the lower index.
  - Then j++. If j==N_OUT go to DONE, else go to ROW_ADDR.
- DONE: oDone=1, oBusy=0. Stay while iValid=1. When iValid=0, return to IDLE and clear oDone. oScores and oDigit are retained until the next run's STORE writes or a reset.
- iValid changes during a run are ignored; the activations are the ones latched in IDLE.
- ena=0: the next state equals the current state in every register; addr_to_rom holds its value.

## Timing
- The edge that samples iValid=1 in IDLE is cycle 0.
- Bias fetch takes 1+ROM_LAT cycles. Each class takes 1+ROM_LAT+N_IN+2 = 133 cycles.
- With defaults, oDone rises at cycle 1+3+10*133 = 1334.
- oScores slot j and oDigit update at the STORE edge of class j. Intermediate values are visible but valid only with oDone=1.
- Every ena=0 cycle adds exactly one cycle of latency.
- oDone falls one cycle after iValid=0 is sampled in DONE. A new run needs iValid to go low then high again.

## Test plan
- Reset: drive iRst_n=0 for 2 cycles with random inputs. Required: all outputs 0, state IDLE; no ROM address activity while iValid=0.
- Bias only: all activations 0; biases j*0x0100, except b[7]=0x0C00. Required: scores equal the biases, oDigit=7, oDone at cycle 1334.
- Single weight: a[0]=0x0400 (1.0), w[j][0]=j*0x0200, all other weights 0, biases 0. Required: score j=j*0x0200, oDigit=9.
- Saturation and ties: all a=0x7FFF, all w=0x7FFF, biases 0. Required: every score 0x7FFF, oDigit=0. Repeat with w=0x8000: every score 0x8000, oDigit=0.
- Negative scores: all scores negative, b[3]=0xFF00 the largest, others below 0xF000, activations 0. Required: oDigit=3.
- Disruption:
  - Assert reset at cycle 500, then rerun the bias-only case. Required: identical result, oDone at cycle 1334 of the new run.
  - Hold ena=0 for 50 cycles mid-MAC. Required: oDone at cycle 1384, same scores.
